// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: bundles the SPI pins and the receive-side status outputs
// of spi_slave_rx.
//   spi_cs_l / spi_sclk / spi_data : serial link from the SPI master
//   dataout / data_valid           : received word and its 1-cycle strobe
//   frame_err                      : 1-cycle pulse on short/over-length frame
//   bit_cnt / frame_cnt / busy     : progress and status
// Modports: slave = the receiver, master = whoever drives the link and
// observes the status.
interface spi_slave_rx_if #(
  parameter int WIDTH = 16
);
  logic             spi_cs_l;
  logic             spi_sclk;
  logic             spi_data;
  logic [WIDTH-1:0] dataout;
  logic             data_valid;
  logic             frame_err;
  logic [4:0]       bit_cnt;
  logic [7:0]       frame_cnt;
  logic             busy;

  modport slave (
    input  spi_cs_l, spi_sclk, spi_data,
    output dataout, data_valid, frame_err, bit_cnt, frame_cnt, busy
  );

  modport master (
    output spi_cs_l, spi_sclk, spi_data,
    input  dataout, data_valid, frame_err, bit_cnt, frame_cnt, busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI mode-0 receiver. Synchronises cs_l/sclk/data
// into clk, deserialises WIDTH-bit MSB-first frames, strobes each good word
// out with data_valid, flags short/over-length frames with frame_err and
// counts good frames.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : spi_slave_rx_if.slave (SPI pins in, word/status out)
module spi_slave_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  spi_slave_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  // ---- synchronisers + edge detect ----
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, data_sync;
  logic                   cs_d, sclk_d;
  // Fills with ones after reset; edges are only trusted once the sync chain
  // and the delay flop hold real samples. A cs held low across reset release
  // therefore never looks like a cs_fall, and the partial frame is dropped.
  logic [SYNC_STAGES:0]   vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      data_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_l};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.spi_data};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic cs_s, sclk_s, data_s, edge_ok;
  logic sclk_rise, cs_fall, cs_rise;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign edge_ok   = vld_pipe[SYNC_STAGES];
  assign sclk_rise = edge_ok &  sclk_s & ~sclk_d;
  assign cs_fall   = edge_ok & ~cs_s   &  cs_d;
  assign cs_rise   = edge_ok &  cs_s   & ~cs_d;

  // ---- FSM ----
  state_t           state_q, state_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic [WIDTH-1:0] dout_q, dout_n;
  logic [4:0]       cnt_q, cnt_n;
  logic [7:0]       fcnt_q, fcnt_n;
  logic             vld_q, vld_n;
  logic             err_q, err_n;
  logic             ovr_q, ovr_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      dout_q  <= dout_n;
      cnt_q   <= cnt_n;
      fcnt_q  <= fcnt_n;
      vld_q   <= vld_n;
      err_q   <= err_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    dout_n  = dout_q;
    cnt_n   = cnt_q;
    fcnt_n  = fcnt_q;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    ovr_n   = ovr_q;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        ovr_n = 1'b0;
        if (cs_fall) state_n = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          shreg_n = {shreg_q[WIDTH-2:0], data_s};
          cnt_n   = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            // Final bit wins over a coincident cs_rise: still a good frame.
            dout_n  = {shreg_q[WIDTH-2:0], data_s};
            vld_n   = 1'b1;
            fcnt_n  = fcnt_q + 8'd1;
            state_n = cs_rise ? IDLE : DONE;
            if (cs_rise) cnt_n = '0;
          end else if (cs_rise) begin
            err_n   = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else if (cs_rise) begin
          err_n   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      DONE: begin
        if (cs_rise) begin
          err_n   = ovr_q;
          ovr_n   = 1'b0;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (sclk_rise) begin
          ovr_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.dataout    = dout_q;
  assign bus.data_valid = vld_q;
  assign bus.frame_err  = err_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.frame_cnt  = fcnt_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench for spi_slave_rx. Drives mode-0 frames with
// a 2-clk sclk, records data_valid/frame_err pulses on the falling clk edge
// and compares against hand-computed words, counts and latencies.
module tb_spi_slave_rx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_rx_if #(.WIDTH(16)) bus ();

  spi_slave_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---- cycle counter and pulse monitor ----
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vld = 0, n_err = 0, n_both = 0, n_long = 0;
  int          vld_cyc = 0, err_cyc = 0;
  logic        vld_prev = 1'b0, err_prev = 1'b0;
  logic [15:0] vq[$];

  always @(negedge clk) begin
    if (bus.data_valid) begin
      n_vld++;
      vq.push_back(bus.dataout);
      vld_cyc = cyc;
      if (vld_prev) n_long++;
    end
    if (bus.frame_err) begin
      n_err++;
      err_cyc = cyc;
      if (err_prev) n_long++;
    end
    if (bus.data_valid && bus.frame_err) n_both++;
    vld_prev = bus.data_valid;
    err_prev = bus.frame_err;
  end

  // ---- master-side drivers ----
  int rise_cyc = 0, cs_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_low(input bit chk_busy);
    bus.spi_cs_l = 1'b0;
    tick();
    tick();
    if (chk_busy) chk("busy_early", {31'd0, bus.busy}, 32'd0);
    tick();
    if (chk_busy) chk("busy_rise", {31'd0, bus.busy}, 32'd1);
  endtask

  // Sends w[msb], w[msb-1], ... for n bits.
  task automatic send_bits(input logic [15:0] w, input int msb, input int n);
    for (int i = 0; i < n; i++) begin
      bus.spi_data = w[msb - i];
      tick();
      bus.spi_sclk = 1'b1;
      rise_cyc = cyc;
      tick();
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    tick();
    bus.spi_cs_l = 1'b1;
    cs_cyc = cyc;
    repeat (6) tick();
  endtask

  task automatic frame(input logic [15:0] w);
    cs_low(1'b0);
    send_bits(w, 15, 16);
    cs_high();
  endtask

  task automatic chk_word(input string tag, input logic [15:0] exp);
    if (vq.size() == 0) chk(tag, 32'hFFFF_FFFF, {16'd0, exp});
    else                chk(tag, {16'd0, vq.pop_front()}, {16'd0, exp});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dout"},  {16'd0, bus.dataout},   32'd0);
    chk({tag, "_vld"},   {31'd0, bus.data_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, bus.frame_err}, 32'd0);
    chk({tag, "_bcnt"},  {27'd0, bus.bit_cnt},   32'd0);
    chk({tag, "_fcnt"},  {24'd0, bus.frame_cnt}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy},      32'd0);
  endtask

  int v0, e0;

  initial begin
    reset        = 1'b1;
    bus.spi_cs_l = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_data = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("rst");
    reset = 1'b0;
    repeat (5) tick();

    // Three good frames; first one also checks busy and valid latency.
    cs_low(1'b1);
    send_bits(16'hA569, 15, 16);
    cs_high();
    chk("vld_lat", vld_cyc - rise_cyc, 32'd3);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    frame(16'h2563);
    frame(16'h9B63);
    chk("n_vld3", n_vld, 32'd3);
    chk_word("w_A569", 16'hA569);
    chk_word("w_2563", 16'h2563);
    chk_word("w_9B63", 16'h9B63);
    chk("fcnt3", {24'd0, bus.frame_cnt}, 32'd3);
    chk("no_err3", n_err, 32'd0);

    // Short frame: 9 bits then cs rises.
    cs_low(1'b0);
    send_bits(16'h6A61, 15, 9);
    repeat (3) tick();
    chk("short_bcnt", {27'd0, bus.bit_cnt}, 32'd9);
    chk("short_busy", {31'd0, bus.busy}, 32'd1);
    cs_high();
    chk("short_err", n_err, 32'd1);
    chk("err_lat", err_cyc - cs_cyc, 32'd3);
    chk("short_dout", {16'd0, bus.dataout}, 32'h9B63);
    chk("short_fcnt", {24'd0, bus.frame_cnt}, 32'd3);
    chk("short_nvld", n_vld, 32'd3);
    frame(16'hA265);
    chk_word("w_A265", 16'hA265);
    chk("fcnt4", {24'd0, bus.frame_cnt}, 32'd4);

    // Over-length: 16 bits + 2 extra edges.
    cs_low(1'b0);
    send_bits(16'h7564, 15, 16);
    repeat (3) tick();
    chk("ovl_word", {16'd0, bus.dataout}, 32'h7564);
    chk("ovl_bcnt", {27'd0, bus.bit_cnt}, 32'd16);
    send_bits(16'h0000, 15, 2);
    repeat (3) tick();
    chk("ovl_bcnt2", {27'd0, bus.bit_cnt}, 32'd16);
    chk("ovl_noerr", n_err, 32'd1);
    cs_high();
    chk_word("w_7564", 16'h7564);
    chk("ovl_err", n_err, 32'd2);
    chk("ovl_err_lat", err_cyc - cs_cyc, 32'd3);
    chk("fcnt5", {24'd0, bus.frame_cnt}, 32'd5);

    // Reset mid-frame.
    v0 = n_vld;
    e0 = n_err;
    cs_low(1'b0);
    send_bits(16'hFFFF, 15, 8);
    reset = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    repeat (2) tick();
    reset = 1'b0;
    send_bits(16'hFFFF, 7, 8);
    cs_high();
    chk("midrst_nvld", n_vld - v0, 32'd0);
    chk("midrst_nerr", n_err - e0, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    frame(16'h0001);
    chk_word("w_0001", 16'h0001);
    chk("fcnt_after_rst", {24'd0, bus.frame_cnt}, 32'd1);

    // sclk toggling with cs high is ignored.
    v0 = n_vld;
    repeat (5) begin
      bus.spi_data = 1'b1;
      tick();
      bus.spi_sclk = 1'b1;
      tick();
      bus.spi_sclk = 1'b0;
    end
    repeat (4) tick();
    chk("idle_bcnt", {27'd0, bus.bit_cnt}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_nvld", n_vld - v0, 32'd0);
    chk("idle_fcnt", {24'd0, bus.frame_cnt}, 32'd1);
    chk("idle_dout", {16'd0, bus.dataout}, 32'h0001);

    // 256 frames from a fresh reset: frame_cnt wraps to 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'(i * 16'h0101 + 16'h1234);
      frame(w);
      chk_word($sformatf("batch%0d", i), w);
      if (i == 254) chk("fcnt255", {24'd0, bus.frame_cnt}, 32'd255);
    end
    chk("fcnt_wrap", {24'd0, bus.frame_cnt}, 32'd0);
    chk("no_both", n_both, 32'd0);
    chk("one_cycle", n_long, 32'd0);
    chk("vq_drained", vq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
